// File: rtl/cnt_capture.sv
// Timestamp capture: samples the upstream counter on each event, extends it with a
// wrap epoch, and queues the stamp in a show-ahead FIFO with saturating drop count.
module cnt_capture #(
  parameter int N     = 64,
  parameter int E     = 16,
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             counter,
  input  logic                     cout,
  input  logic                     evt,
  output logic                     out_valid,
  output logic [N+E-1:0]           out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [DW-1:0]            drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FILL_ONE = (AW+1)'(1);
  localparam logic [AW:0]   FILL_MAX = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] v);
    return (&v) ? v : v + DW'(1);
  endfunction

  logic [E-1:0]     epoch_q;
  logic [E-1:0]     epoch_p0;
  logic [N+E-1:0]   stamp_p0;
  logic [N+E-1:0]   mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             full;
  logic             push;
  logic             pop;
  logic             drop;

  // Capture stage: a carry in the event cycle already counts toward the stamp's epoch.
  assign epoch_p0 = epoch_q + E'(cout);
  assign stamp_p0 = {epoch_p0, counter};

  assign full      = (fill == FILL_MAX);
  assign out_valid = (fill != '0);
  assign pop       = out_valid & out_ready;
  assign push      = evt & (~full | pop);
  assign drop      = evt & full & ~pop;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      epoch_q  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fill     <= '0;
      drop_cnt <= '0;
    end else begin
      epoch_q <= epoch_p0;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fill <= fill + FILL_ONE;
        2'b01:   fill <= fill - FILL_ONE;
        default: fill <= fill;
      endcase
      if (drop) drop_cnt <= sat_inc(drop_cnt);
    end
  end

  // Storage stage: entries are meaningless until fill covers them, so no reset here.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= stamp_p0;
  end

endmodule

// File: tb/tb_cnt_capture.sv
// Bench for cnt_capture: two instances (E=16/DW=8 and E=2/DW=2) share stimulus and are
// compared each cycle against a queue-based reference model.
module tb_cnt_capture;
  localparam int N     = 64;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, cout, evt, out_ready;
  logic [N-1:0] counter;

  logic        va, vb;
  logic [79:0] da;
  logic [65:0] db;
  logic [2:0]  fa, fb;
  logic [7:0]  dca;
  logic [1:0]  dcb;

  cnt_capture #(.N(N), .E(16), .DEPTH(DEPTH), .DW(8)) dut_a (
    .clk(clk), .rst(rst), .counter(counter), .cout(cout), .evt(evt),
    .out_valid(va), .out_data(da), .out_ready(out_ready), .fill(fa), .drop_cnt(dca));

  cnt_capture #(.N(N), .E(2), .DEPTH(DEPTH), .DW(2)) dut_b (
    .clk(clk), .rst(rst), .counter(counter), .cout(cout), .evt(evt),
    .out_valid(vb), .out_data(db), .out_ready(out_ready), .fill(fb), .drop_cnt(dcb));

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] cnt;
    int          ep;
  } ent_t;

  ent_t q[$];
  int   epoch_cnt = 0;
  int   drops = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [31:0] e;
    int          sz;
    sz = q.size();
    chk("valid_a", 128'(va), 128'(sz != 0));
    chk("valid_b", 128'(vb), 128'(sz != 0));
    chk("fill_a", 128'(fa), 128'(sz));
    chk("fill_b", 128'(fb), 128'(sz));
    chk("drop_a", 128'(dca), 128'((drops > 255) ? 255 : drops));
    chk("drop_b", 128'(dcb), 128'((drops > 3) ? 3 : drops));
    if (sz != 0) begin
      e = q[0].ep;
      chk("data_a", 128'(da), 128'({e[15:0], q[0].cnt}));
      chk("data_b", 128'(db), 128'({e[1:0], q[0].cnt}));
    end
  endtask

  task automatic model_update(input logic r, input logic e, input logic c,
                              input logic rd, input logic [63:0] cnt);
    ent_t n;
    logic p_pop, p_push;
    if (r) begin
      q.delete();
      epoch_cnt = 0;
      drops = 0;
    end else begin
      p_pop  = (q.size() != 0) && rd;
      p_push = e && ((q.size() < DEPTH) || p_pop);
      if (e && !p_push) drops++;
      n.cnt = cnt;
      n.ep  = epoch_cnt + int'(c);
      if (p_pop) void'(q.pop_front());
      if (p_push) q.push_back(n);
      epoch_cnt += int'(c);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic c, input logic rd,
                      input logic [63:0] cnt);
    rst = r; evt = e; cout = c; out_ready = rd; counter = cnt;
    check_model();
    model_update(r, e, c, rd, cnt);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int ep_exp[4];
    ep_exp = '{1, 2, 3, 0};
    rst = 1'b1; evt = 1'b0; cout = 1'b0; out_ready = 1'b0; counter = '0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    chk("rst_data_a", 128'(da), 128'(0));

    // Single capture of 0x1234 into an empty FIFO.
    step(1'b0, 1'b1, 1'b0, 1'b1, 64'h1234);
    chk("t1_valid", 128'(va), 128'(1));
    chk("t1_data", 128'(da), 128'({16'h0, 64'h1234}));
    step(1'b0, 1'b0, 1'b0, 1'b1, rnd64());
    chk("t1_fill", 128'(fa), 128'(0));

    // Carry bypass around events.
    step(1'b0, 1'b1, 1'b0, 1'b1, rnd64());
    chk("ep_before", 128'(da[79:64]), 128'(0));
    step(1'b0, 1'b1, 1'b1, 1'b1, rnd64());
    chk("ep_bypass", 128'(da[79:64]), 128'(1));
    step(1'b0, 1'b1, 1'b0, 1'b1, rnd64());
    chk("ep_after", 128'(da[79:64]), 128'(1));
    step(1'b0, 1'b0, 1'b0, 1'b1, rnd64());

    // Overflow with consumer stalled.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0, rnd64());
    chk("ovf_fill", 128'(fa), 128'(4));
    chk("ovf_drop", 128'(dca), 128'(2));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, rnd64());
    chk("drain_fill", 128'(fa), 128'(0));

    // Full FIFO with simultaneous pop and push.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, rnd64());
    step(1'b0, 1'b1, 1'b0, 1'b1, rnd64());
    chk("fullpp_fill", 128'(fa), 128'(4));
    chk("fullpp_drop", 128'(dca), 128'(2));

    // Drop counter saturation on the narrow instance.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, rnd64());
    chk("sat_drop_b", 128'(dcb), 128'(3));
    chk("sat_drop_a", 128'(dca), 128'(7));

    // Reset while partially full with an event pending.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, rnd64());
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, rnd64());
    chk("pre_rst_fill", 128'(fa), 128'(3));
    step(1'b1, 1'b1, 1'b1, 1'b0, rnd64());
    chk("rst_valid", 128'(va), 128'(0));
    chk("rst_fill", 128'(fa), 128'(0));
    chk("rst_drop", 128'(dca), 128'(0));
    step(1'b0, 1'b1, 1'b0, 1'b1, rnd64());
    chk("post_rst_ep", 128'(da[79:64]), 128'(0));

    // Epoch wrap on the 2-bit instance.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, rnd64());
      chk("wrap_ep_b", 128'(db[65:64]), 128'(ep_exp[i]));
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, rnd64());

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 97) == 0, ($urandom % 3) != 0, ($urandom % 6) == 0,
           ($urandom % 3) != 0, rnd64());
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, rnd64());

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
